// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative 32-bit restoring divider for DIV/DIVU
//
// Purpose: one quotient bit per clock; returns {remainder, quotient} with
// sign correction applied on the edge after the last iteration.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   signed_div_i         1 = signed (DIV), 0 = unsigned (DIVU)
//   opdata1_i/opdata2_i  dividend / divisor, sampled only on the start edge
//   start_i, annul_i     request (held until ready_o) / cancel
//   result_o, ready_o    registered {remainder, quotient} and result valid
module div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  typedef enum logic [1:0] {ST_FREE, ST_BYZERO, ST_ON, ST_END} state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d;     // partial remainder
  logic [31:0] quo_q, quo_d;     // dividend bits shift out, quotient bits shift in
  logic [31:0] dsor_q, dsor_d;   // divisor magnitude
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;
  logic [63:0] result_q, result_d;
  logic        ready_q, ready_d;

  logic [32:0] trial;
  logic [31:0] quo_fix, rem_fix;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dsor_d    = dsor_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    ready_d   = ready_q;

    // Partial remainder is always below the divisor, so {rem, next bit} fits
    // 33 bits and bit 32 of the difference is a reliable sign.
    trial   = {rem_q, quo_q[31]} - {1'b0, dsor_q};
    quo_fix = neg_quo_q ? (~quo_q + 32'd1) : quo_q;
    rem_fix = neg_rem_q ? (~rem_q + 32'd1) : rem_q;

    case (state_q)
      ST_FREE: begin
        result_d = 64'h0;
        ready_d  = 1'b0;
        if (start_i && !annul_i) begin
          if (opdata2_i == 32'h0) begin
            state_d = ST_BYZERO;
          end else begin
            state_d   = ST_ON;
            cnt_d     = 6'd0;
            rem_d     = 32'h0;
            quo_d     = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
            dsor_d    = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;
            neg_quo_d = signed_div_i && (opdata1_i[31] ^ opdata2_i[31]);
            neg_rem_d = signed_div_i && opdata1_i[31];
          end
        end
      end
      ST_BYZERO: begin
        result_d = 64'h0;
        if (annul_i) begin
          state_d = ST_FREE;
          ready_d = 1'b0;
        end else begin
          state_d = ST_END;
          ready_d = 1'b1;
        end
      end
      ST_ON: begin
        if (annul_i) begin
          state_d  = ST_FREE;
          result_d = 64'h0;
          ready_d  = 1'b0;
        end else if (cnt_q == 6'd32) begin
          state_d  = ST_END;
          result_d = {rem_fix, quo_fix};
          ready_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 6'd1;
          if (!trial[32]) begin
            rem_d = trial[31:0];
            quo_d = {quo_q[30:0], 1'b1};
          end else begin
            rem_d = {rem_q[30:0], quo_q[31]};
            quo_d = {quo_q[30:0], 1'b0};
          end
        end
      end
      ST_END: begin
        // annul_i deliberately ignored: the result is already committed.
        if (!start_i) begin
          state_d  = ST_FREE;
          result_d = 64'h0;
          ready_d  = 1'b0;
        end
      end
      default: begin
        state_d  = ST_FREE;
        result_d = 64'h0;
        ready_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_FREE;
      cnt_q     <= 6'd0;
      rem_q     <= 32'h0;
      quo_q     <= 32'h0;
      dsor_q    <= 32'h0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= 64'h0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dsor_q    <= dsor_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - scoreboard bench for div_unit
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        signed_div_i = 1'b0;
  logic [31:0] opdata1_i = 32'h0;
  logic [31:0] opdata2_i = 32'h0;
  logic        start_i = 1'b0;
  logic        annul_i = 1'b0;
  logic [63:0] result_o;
  logic        ready_o;

  div_unit dut (
    .clk(clk), .rst(rst), .signed_div_i(signed_div_i),
    .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
    .start_i(start_i), .annul_i(annul_i),
    .result_o(result_o), .ready_o(ready_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] res;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic rdy_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, want);
    end
  endtask

  // Monitor: every rising ready_o must match the oldest expected result,
  // both in value and in the cycle it appears.
  always @(negedge clk) begin
    if (!rst && ready_o && !rdy_prev) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_ready", 64'(ready_o), 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("result", result_o, e.res);
        chk("latency", 64'(cyc), 64'(e.cyc));
      end
    end
    rdy_prev = ready_o;
  end

  // Called at a negedge just before the E0 edge.
  task automatic push_exp(input logic [63:0] res, input int lat);
    exp_t e;
    e.res = res;
    e.cyc = cyc + 1 + lat;
    exp_q.push_back(e);
  endtask

  task automatic wait_done(input logic [63:0] want, input int hold);
    int n;
    n = 0;
    while (!ready_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ready_o) chk("timeout", 64'(ready_o), 64'd1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_ready", 64'(ready_o), 64'd1);
      chk("hold_result", result_o, want);
    end
    start_i = 1'b0;
    @(negedge clk);
    chk("drop_ready", 64'(ready_o), 64'd0);
    chk("drop_result", result_o, 64'h0);
  endtask

  task automatic run(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                     input logic [63:0] want, input int lat, input int hold);
    @(negedge clk);
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    push_exp(want, lat);
    wait_done(want, hold);
  endtask

  initial begin
    #1;
    chk("reset_ready", 64'(ready_o), 64'd0);
    chk("reset_result", result_o, 64'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33, 0);
    run(1'b1, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 33, 0);
    run(1'b1, 32'd7, 32'hFFFFFFFE, {32'd1, 32'hFFFFFFFD}, 33, 0);
    run(1'b0, 32'hFFFFFFFF, 32'h10, {32'hF, 32'h0FFFFFFF}, 33, 0);
    run(1'b1, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000}, 33, 0);
    run(1'b0, 32'h80000000, 32'hFFFFFFFF, {32'h80000000, 32'h0}, 33, 0);
    run(1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, {32'hFFFFFFFE, 32'd14}, 33, 1);
    run(1'b0, 32'd55, 32'd0, 64'h0, 1, 3);
    run(1'b1, 32'hFFFFFFF0, 32'd0, 64'h0, 1, 3);

    // Annul sampled at E10: no result may appear.
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
    repeat (10) @(negedge clk);
    annul_i = 1'b1;
    @(negedge clk);
    annul_i = 1'b0;
    start_i = 1'b0;
    repeat (40) @(negedge clk);
    chk("annul_no_ready", 64'(ready_o), 64'd0);
    run(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33, 0);

    // Asynchronous reset at E20, then restart with start_i still high.
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
    repeat (21) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_ready", 64'(ready_o), 64'd0);
    chk("rst_mid_result", result_o, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    push_exp({32'd2, 32'd14}, 33);
    wait_done({32'd2, 32'd14}, 0);

    // Asynchronous reset while a result is being held in END.
    @(negedge clk);
    signed_div_i = 1'b1; opdata1_i = 32'hFFFFFFF9; opdata2_i = 32'd2; start_i = 1'b1;
    push_exp({32'hFFFFFFFF, 32'hFFFFFFFD}, 33);
    repeat (36) @(negedge clk);
    chk("end_held_ready", 64'(ready_o), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_end_ready", 64'(ready_o), 64'd0);
    chk("rst_end_result", result_o, 64'h0);
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_unit.md
# div_unit

Iterative 32-bit integer divider for the EX stage, serving DIV/DIVU. It takes operands from EX and returns `{remainder, quotient}` for the HI/LO write path. It sets `ready_o` when the result is available. While `start_i & ~ready_o` holds, EX raises its stall request to the pipeline controller, so stall code `6'b001111` freezes PC, IF/ID, ID/EX and EX/MEM until the divide completes.

## Interface
Parameters: none; width fixed at 32 bits.

Ports:
- `clk`  in  1  pipeline clock; all state updates on the rising edge
- `rst`  in  1  asynchronous, active-high reset
- `signed_div_i`  in  1  1 = signed (DIV), 0 = unsigned (DIVU)
- `opdata1_i`  in  32  dividend
- `opdata2_i`  in  32  divisor
- `start_i`  in  1  request; EX holds it high until `ready_o` is seen
- `annul_i`  in  1  cancel request (exception or flush)
- `result_o`  out  64  `{remainder[63:32], quotient[31:0]}`
- `ready_o`  out  1  result valid

## Operation
- Outputs are registered. On reset: `state=FREE`, `cnt=0`, `result_o=64'h0`, `ready_o=0`.
- Operand capture happens in FREE, on the edge that starts a divide.
  - Signed mode: each negative operand is converted to its two's-complement magnitude.
  - Signs of dividend and divisor are recorded.
  - Operands are not re-sampled after capture.
- State FREE:
  - `start_i & ~annul_i` with divisor 0 -> BYZERO.
  - `start_i & ~annul_i` with divisor ≠ 0 -> ON, `cnt=0`, operands captured.
  - Otherwise stay in FREE, with `ready_o=0` and `result_o=0`.
- State BYZERO:
  - Next edge -> END with `result_o=64'h0` and `ready_o=1`.
  - If `annul_i`, go to FREE instead.
- State ON, restoring division with one quotient bit per edge:
  - Compute a 33-bit trial subtraction of the divisor magnitude from the partial remainder.
  - If the result is non-negative, shift in quotient bit 1 and keep the difference; otherwise shift in 0 and keep the remainder.
  - `cnt` increments each iteration.
  - When `cnt==32`, the next edge applies sign correction and goes to END with `ready_o=1`:
    - quotient is negated when signed and operand signs differ;
    - remainder is negated when signed and the dividend is negative.
  - `annul_i` high at any edge in ON -> FREE, outputs cleared, no result.
- State END:
  - Hold `result_o` and `ready_o=1` while `start_i=1`.
  - `start_i=0` -> FREE, with `result_o=0` and `ready_o=0`.
  - `annul_i` is ignored in END.
- Arithmetic: all results are truncated to 32 bits per half.
  - Signed `0x80000000 / 0xFFFFFFFF` gives quotient `0x80000000`, remainder `0`.
  - Divisor-zero result is architecturally undefined; this block defines it as all zeros.

## Timing
- Edge E0 is the first edge where FREE sees `start_i & ~annul_i`.
- Normal divide:
  - Iterations occur on E1..E32.
  - Sign fix occurs on E33.
  - `ready_o` is high after E33, i.e. 33 stall cycles beyond the issue cycle.
- Divide by zero: `ready_o` is high after E1.
- `ready_o` deasserts on the first edge in END where `start_i=0`.
- Back-to-back requests: `start_i` must go low for at least one edge (END->FREE) before the next request is accepted. A new request is sampled in FREE no earlier than the edge after leaving END.
- Reset asserted mid-operation returns the block to FREE immediately, with outputs cleared and independent of `clk`.

## Test plan
- Unsigned `100 / 7` -> after E33, `ready_o=1`, `result_o={32'd2, 32'd14}`. `ready_o` must be 0 on every cycle before.
- Signed `0xFFFFFFF9 (-7) / 2` -> quotient `0xFFFFFFFD`, remainder `0xFFFFFFFF`. Signed `7 / 0xFFFFFFFE` -> quotient `0xFFFFFFFD`, remainder `1`.
- Unsigned `0xFFFFFFFF / 0x10` -> `{32'hF, 32'h0FFFFFFF}`. Signed `0x80000000 / 0xFFFFFFFF` -> `{32'h0, 32'h80000000}`.
- Divisor 0 (either mode) -> `ready_o=1` after E1, `result_o=0`. Hold `start_i` 3 extra cycles: outputs stable. Drop `start_i`: `ready_o=0` next edge.
- `annul_i` pulsed at E10 during ON -> FREE, `ready_o` never asserts. Then a new `100 / 7` request completes correctly 33 edges after its own E0.
- Assert `rst` asynchronously at E20 of a divide -> `ready_o`/`result_o` go 0 immediately. After release, `start_i` still high restarts the divide from FREE.
